// File: rtl/audio_seq_pkg.sv
// Shared types and defaults for the audio filter sequencer.
// Holds the frame FSM encoding and the Q0.COEF_W unity constant.
package audio_seq_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int COEF_W_DEF   = 8;
    localparam int COEF_ONE     = 1 << COEF_W_DEF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/audio_filter_sequencer_blend.sv
// Combinational one-pole blend: y = (a*x + (1-a)*y_prev) >>> COEF_W.
// Shared by both channels; bypass passes x straight through.
module audio_blend_unit
    import audio_seq_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int COEF_W   = COEF_W_DEF
) (
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic signed [SAMPLE_W-1:0] y_prev,
    input  logic        [COEF_W-1:0]   alpha,
    input  logic                       bypass,
    output logic signed [SAMPLE_W-1:0] y_new
);

    localparam int W = SAMPLE_W + COEF_W + 2;
    localparam logic signed [W-1:0] ONE = W'(1 << COEF_W);

    logic signed [W-1:0] xe;
    logic signed [W-1:0] ye;
    logic signed [W-1:0] ae;
    logic signed [W-1:0] be;
    logic signed [W-1:0] acc;

    assign xe  = {{(W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
    assign ye  = {{(W-SAMPLE_W){y_prev[SAMPLE_W-1]}}, y_prev};
    assign ae  = {{(W-COEF_W){1'b0}}, alpha};
    assign be  = ONE - ae;
    assign acc = (ae * xe) + (be * ye);

    // Arithmetic shift gives floor division for negative sums.
    assign y_new = bypass ? x : SAMPLE_W'(acc >>> COEF_W);

endmodule

// File: rtl/audio_filter_sequencer.sv
// Frame sequencer: filters left then right through one blend unit.
// Define AUDIO_SEQ_OVERRUN_EN to enable the sticky overrun flag.
module audio_filter_sequencer
    import audio_seq_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int COEF_W   = COEF_W_DEF
) (
    input  logic                  AUD_BCLK,
    input  logic                  rst,
    input  logic                  AUD_DACLRCK,
    input  logic [2*SAMPLE_W-1:0] audioIn,
    input  logic [COEF_W-1:0]     coef_alpha,
    input  logic                  bypass,
    output logic [2*SAMPLE_W-1:0] audioOut,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    seq_state_e state;

    logic                       lrck_q;
    logic                       frame_start;
    logic [2*SAMPLE_W-1:0]      in_q;
    logic [COEF_W-1:0]          alpha_q;
    logic                       bypass_q;
    logic signed [SAMPLE_W-1:0] y_left;
    logic signed [SAMPLE_W-1:0] y_right;
    logic signed [SAMPLE_W-1:0] x_sel;
    logic signed [SAMPLE_W-1:0] y_sel;
    logic signed [SAMPLE_W-1:0] y_new;

    assign frame_start = AUD_DACLRCK & ~lrck_q;
    assign busy        = (state != S_IDLE);

    // LEFT feeds the left channel; every other state presents right.
    assign x_sel = (state == S_LEFT) ? $signed(in_q[2*SAMPLE_W-1:SAMPLE_W])
                                     : $signed(in_q[SAMPLE_W-1:0]);
    assign y_sel = (state == S_LEFT) ? y_left : y_right;

    audio_blend_unit #(
        .SAMPLE_W (SAMPLE_W),
        .COEF_W   (COEF_W)
    ) u_blend (
        .x      (x_sel),
        .y_prev (y_sel),
        .alpha  (alpha_q),
        .bypass (bypass_q),
        .y_new  (y_new)
    );

    always_ff @(posedge AUD_BCLK or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            lrck_q    <= 1'b0;
            in_q      <= '0;
            alpha_q   <= '0;
            bypass_q  <= 1'b0;
            y_left    <= '0;
            y_right   <= '0;
            audioOut  <= '0;
            out_valid <= 1'b0;
        end else begin
            lrck_q    <= AUD_DACLRCK;
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        in_q     <= audioIn;
                        alpha_q  <= coef_alpha;
                        bypass_q <= bypass;
                        state    <= S_LEFT;
                    end
                end
                S_LEFT: begin
                    y_left <= y_new;
                    state  <= S_RIGHT;
                end
                S_RIGHT: begin
                    y_right   <= y_new;
                    audioOut  <= {y_left, y_new};
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AUDIO_SEQ_OVERRUN_EN
    always_ff @(posedge AUD_BCLK or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (frame_start && state != S_IDLE) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_audio_filter_sequencer.sv
// Self-checking bench for audio_filter_sequencer.
// Directed table, corner sequences and a randomized model comparison.
module tb_audio_filter_sequencer;

    localparam int SW  = 16;
    localparam int CW  = 8;
    localparam int ONE = 1 << CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          lrck;
    logic [31:0]   din;
    logic [7:0]    alpha;
    logic          byp;
    logic [31:0]   dout;
    logic          oval;
    logic          busy;
    logic          ovr;

    int compared   = 0;
    int mismatched = 0;
    int ml = 0;
    int mr = 0;

    typedef struct {
        logic [31:0] din;
        logic [7:0]  alpha;
        logic        byp;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    audio_filter_sequencer #(
        .SAMPLE_W (SW),
        .COEF_W   (CW)
    ) dut (
        .AUD_BCLK    (clk),
        .rst         (rst),
        .AUD_DACLRCK (lrck),
        .audioIn     (din),
        .coef_alpha  (alpha),
        .bypass      (byp),
        .audioOut    (dout),
        .out_valid   (oval),
        .busy        (busy),
        .overrun     (ovr)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: floor((a*x + (ONE-a)*y) / ONE), or x on bypass.
    function automatic int blend(int x, int yp, int a, bit b);
        longint n;
        longint q;
        logic [15:0] t;
        if (b) return x;
        n = longint'(a) * x + longint'(ONE - a) * yp;
        q = n / ONE;
        if ((n % ONE) != 0 && n < 0) q = q - 1;
        t = q[15:0];
        return int'($signed(t));
    endfunction

    function automatic logic [31:0] model_frame(logic [31:0] d, int a, bit b);
        int xl;
        int xr;
        logic [15:0] hl;
        logic [15:0] hr;
        xl = int'($signed(d[31:16]));
        xr = int'($signed(d[15:0]));
        ml = blend(xl, ml, a, b);
        mr = blend(xr, mr, a, b);
        hl = ml[15:0];
        hr = mr[15:0];
        return {hl, hr};
    endfunction

    // One frame; inputs are scrambled after capture to prove they are held.
    task automatic frame(input logic [31:0] d, input logic [7:0] a,
                         input logic b, output logic [31:0] got,
                         output int lat);
        din   = d;
        alpha = a;
        byp   = b;
        lrck  = 1'b1;
        lat   = 0;
        got   = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                lrck  = 1'b0;
                din   = $urandom;
                alpha = 8'($urandom);
                byp   = 1'($urandom);
            end
            if (oval) begin
                lat = k;
                got = dout;
                break;
            end
        end
        tick();
        check("out_valid one cycle", {31'd0, oval}, 32'd0);
        check("busy back low", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] got;
    logic [31:0] exp;
    int          lat;
    int          pulses;
    logic [7:0]  ra;
    logic        rb;
    logic [31:0] rd;
    logic        exp_ovr;

    initial begin
`ifdef AUDIO_SEQ_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        vecs[0] = '{32'h03E8_FC18, 8'd128, 1'b0, 32'h01F4_FE0C};
        vecs[1] = '{32'h03E8_FC18, 8'd128, 1'b0, 32'h02EE_FD12};
        vecs[2] = '{32'h7FFF_8000, 8'd37,  1'b1, 32'h7FFF_8000};
        vecs[3] = '{32'h1234_5678, 8'd0,   1'b0, 32'h7FFF_8000};

        rst   = 1'b0;
        lrck  = 1'b0;
        din   = 32'hDEAD_BEEF;
        alpha = 8'd200;
        byp   = 1'b0;
        tick();
        tick();
        check("reset audioOut", dout, 32'd0);
        check("reset out_valid", {31'd0, oval}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset overrun", {31'd0, ovr}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            frame(vecs[i].din, vecs[i].alpha, vecs[i].byp, got, lat);
            exp = model_frame(vecs[i].din, vecs[i].alpha, vecs[i].byp);
            check($sformatf("vec%0d audioOut", i), got, vecs[i].exp);
            check($sformatf("vec%0d model", i), got, exp);
            check($sformatf("vec%0d latency", i), lat, 32'd3);
        end
        check("no overrun yet", {31'd0, ovr}, 32'd0);

        // Second rising edge while the frame is still running.
        rd = 32'h0400_F000;
        din   = rd;
        alpha = 8'd64;
        byp   = 1'b0;
        lrck  = 1'b1;
        pulses = 0;
        got = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) lrck = 1'b0;
            if (k == 2) begin
                lrck = 1'b1;
                din  = 32'h1111_2222;
            end
            if (k == 3) lrck = 1'b0;
            if (oval) begin
                pulses++;
                got = dout;
            end
        end
        exp = model_frame(rd, 64, 1'b0);
        check("overrun single pulse", pulses, 32'd1);
        check("overrun frame data", got, exp);
        check("overrun flag", {31'd0, ovr}, {31'd0, exp_ovr});

        // Reset in the middle of a frame.
        din   = 32'h2222_3333;
        alpha = 8'd90;
        lrck  = 1'b1;
        tick();
        check("busy in LEFT", {31'd0, busy}, 32'd1);
        lrck = 1'b0;
        rst  = 1'b0;
        #1;
        check("abort audioOut", dout, 32'd0);
        check("abort out_valid", {31'd0, oval}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort overrun", {31'd0, ovr}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (oval) pulses++;
        end
        check("abort no pulse", pulses, 32'd0);
        rst = 1'b1;
        ml = 0;
        mr = 0;
        tick();
        frame(32'h03E8_FC18, 8'd128, 1'b0, got, lat);
        exp = model_frame(32'h03E8_FC18, 128, 1'b0);
        check("post-reset audioOut", got, 32'h01F4_FE0C);
        check("post-reset model", got, exp);
        check("post-reset latency", lat, 32'd3);

        // Random frames with alpha extremes mixed in.
        for (int i = 0; i < 40; i++) begin
            rd = $urandom;
            ra = 8'($urandom);
            if (i % 10 == 3) ra = 8'd0;
            if (i % 10 == 7) ra = 8'd255;
            rb = ($urandom_range(0, 7) == 0);
            frame(rd, ra, rb, got, lat);
            exp = model_frame(rd, ra, rb);
            check($sformatf("rand%0d audioOut", i), got, exp);
            check($sformatf("rand%0d latency", i), lat, 32'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
